// File: rtl/vga_mem_pkg.sv
// ---------------------------------------------------------------------------
// vga_mem_pkg
//   Shared types and default sizes for the display-memory arbiter.
//   owner_t      : who receives the read data travelling down the tag pipe.
//   port_state_t : operation issued on the memory port in a given cycle.
//   owner_of()   : maps an issued operation to the owner tag it launches.
// ---------------------------------------------------------------------------
package vga_mem_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_WBUF_DEPTH = 4;
    localparam int DEF_RD_LAT     = 1;
    localparam int DEF_STARVE_MAX = 64;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_CORE
    } owner_t;

    typedef enum logic [1:0] {
        IDLE,
        VGA_RD,
        WR,
        CORE_RD
    } port_state_t;

    // Only reads launch a tag; writes and idle slots return nothing.
    function automatic owner_t owner_of(port_state_t op);
        case (op)
            VGA_RD:  return OWN_VGA;
            CORE_RD: return OWN_CORE;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vga_mem_arbiter_wbuf_fifo.sv
// ---------------------------------------------------------------------------
// wbuf_fifo
//   Posted-write buffer: synchronous FIFO of DEPTH entries, WIDTH bits each.
//   The head entry is read straight out of the storage registers, so a pop
//   consumes the value presented during the same cycle.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     push, din  : write din at the tail (ignored when full)
//     pop        : drop the head entry (ignored when empty)
//     head       : current head entry
//     full/empty : occupancy flags derived from level
//     level      : registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push is judged against the current level only, so a full buffer
    // refuses it even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign head  = storage[rd_ptr];

    // NOTE: the storage array has no reset; stale entries are never visible
    // because level and the pointers are reset, and leaving it out keeps the
    // array mappable onto plain flops or RAM without a reset fan-out.
    always_ff @(posedge clk) begin
        // NOTE: clocked state is always updated with non-blocking assignments
        // so every register samples the pre-edge values of its neighbours.
        if (do_push) begin
            storage[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vga_mem_arbiter
//   Shares the single display-memory port between the VGA pixel fetcher and
//   the pipeline core. Per cycle it issues, in priority order: a VGA read, a
//   buffered core write, a core read (only once the write buffer is empty),
//   or nothing. Read data is steered back to its requester by an owner-tag
//   pipeline that tracks the memory read latency.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     vga_req/vga_addr           : pixel read request
//     vga_data/vga_valid         : returned pixel, one pulse per request
//     core_req/we/addr/wdata     : core request (we=1 write, we=0 read)
//     core_gnt                   : combinational accept for this cycle
//     core_rdata/core_rvalid     : core read data and valid pulse
//     mem_addr/wdata/we/re       : registered memory port command
//     mem_rdata                  : memory read data, RD_LAT after mem_re
//     wbuf_level                 : posted-write buffer occupancy
//     core_starved               : core held off by VGA for STARVE_MAX cycles
// ---------------------------------------------------------------------------
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WBUF_DEPTH = DEF_WBUF_DEPTH,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               vga_req,
    input  logic [ADDR_W-1:0]                  vga_addr,
    output logic [DATA_W-1:0]                  vga_data,
    output logic                               vga_valid,
    input  logic                               core_req,
    input  logic                               core_we,
    input  logic [ADDR_W-1:0]                  core_addr,
    input  logic [DATA_W-1:0]                  core_wdata,
    output logic                               core_gnt,
    output logic [DATA_W-1:0]                  core_rdata,
    output logic                               core_rvalid,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_wdata,
    output logic                               mem_we,
    output logic                               mem_re,
    input  logic [DATA_W-1:0]                  mem_rdata,
    output logic [$clog2(WBUF_DEPTH+1)-1:0]    wbuf_level,
    output logic                               core_starved
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_SAT = CNT_W'(STARVE_MAX);

    port_state_t        state;
    port_state_t        next_state;
    owner_t             tag_pipe [RD_LAT+1];
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic               push;
    logic               pop;
    logic               core_rd_inflight;
    logic               core_pending;
    logic [CNT_W-1:0]   starve_cnt;

    wbuf_fifo #(
        .DEPTH (WBUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wbuf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({core_addr, core_wdata}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (wbuf_level)
    );

    // A core read is in flight from the cycle its tag enters the pipe until
    // its data is captured; only one may be outstanding.
    always_comb begin
        core_rd_inflight = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            if (tag_pipe[i] == OWN_CORE) core_rd_inflight = 1'b1;
        end
    end

    // Port scheduler: picks this cycle's operation and the core handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        next_state = IDLE;
        core_gnt   = 1'b0;

        if (vga_req) begin
            next_state = VGA_RD;
        end else if (!fifo_empty) begin
            next_state = WR;
        end else if (core_req && !core_we && !core_rd_inflight) begin
            next_state = CORE_RD;
        end

        // Writes are posted regardless of VGA traffic; reads are granted
        // only when they are actually issued.
        if (core_req && core_we) begin
            core_gnt = !fifo_full;
        end else if (core_req) begin
            core_gnt = (next_state == CORE_RD);
        end

        if (reset) begin
            core_gnt = 1'b0;
        end
    end

    assign push         = core_gnt && core_we;
    assign pop          = (next_state == WR);
    assign core_pending = !fifo_empty || (core_req && !core_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobes come straight from the state register, so they are registered.
    assign mem_we = (state == WR);
    assign mem_re = (state == VGA_RD) || (state == CORE_RD);

    // Address and write data for the issued operation; held while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (next_state)
                VGA_RD:  mem_addr <= vga_addr;
                CORE_RD: mem_addr <= core_addr;
                WR: begin
                    mem_addr  <= fifo_head[ENTRY_W-1:DATA_W];
                    mem_wdata <= fifo_head[DATA_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Tag k is aligned with the cycle that is k cycles after mem_re, so
    // tag_pipe[RD_LAT] marks the cycle in which mem_rdata is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_pipe[i] <= OWN_NONE;
            end
        end else begin
            tag_pipe[0] <= owner_of(next_state);
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_valid   <= 1'b0;
            vga_data    <= '0;
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
        end else begin
            vga_valid   <= (tag_pipe[RD_LAT] == OWN_VGA);
            core_rvalid <= (tag_pipe[RD_LAT] == OWN_CORE);
            if (tag_pipe[RD_LAT] == OWN_VGA)  vga_data   <= mem_rdata;
            if (tag_pipe[RD_LAT] == OWN_CORE) core_rdata <= mem_rdata;
        end
    end

    // Counts cycles where the core has work but VGA takes the port; any
    // core-side issue clears it. Status only, priority is unaffected.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (next_state == WR || next_state == CORE_RD) begin
            starve_cnt <= '0;
        end else if (next_state == VGA_RD && core_pending && starve_cnt != STARVE_SAT) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign core_starved = (starve_cnt == STARVE_SAT);

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_mem_arbiter
//   Directed bench for vga_mem_arbiter with default parameters. A behavioural
//   memory answers reads one cycle after mem_re: written locations return
//   their stored byte, untouched ones return addr[7:0] + 0x40.
//   Each step drives inputs 1 time unit after a rising edge and samples
//   outputs 1 unit later, so registered outputs reflect the previous cycle.
// ---------------------------------------------------------------------------
module tb_vga_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic [7:0]  vga_data;
    logic        vga_valid;
    logic        core_req;
    logic        core_we;
    logic [15:0] core_addr;
    logic [7:0]  core_wdata;
    logic        core_gnt;
    logic [7:0]  core_rdata;
    logic        core_rvalid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic [2:0]  wbuf_level;
    logic        core_starved;

    int total = 0;
    int bad   = 0;

    vga_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .vga_req      (vga_req),
        .vga_addr     (vga_addr),
        .vga_data     (vga_data),
        .vga_valid    (vga_valid),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_gnt     (core_gnt),
        .core_rdata   (core_rdata),
        .core_rvalid  (core_rvalid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .wbuf_level   (wbuf_level),
        .core_starved (core_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory, read latency 1.
    logic [7:0] store   [65536];
    bit         written [65536];

    always @(posedge clk) begin
        if (reset) begin
            mem_rdata <= 8'h00;
        end else begin
            if (mem_we) begin
                store[mem_addr]   <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end
            if (mem_re) begin
                mem_rdata <= written[mem_addr] ? store[mem_addr] : 8'(mem_addr[7:0] + 8'h40);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic vr, input logic [15:0] va, input logic cr,
                       input logic cw, input logic [15:0] ca, input logic [7:0] cd);
        @(posedge clk);
        #1;
        vga_req    = vr;
        vga_addr   = va;
        core_req   = cr;
        core_we    = cw;
        core_addr  = ca;
        core_wdata = cd;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " vga_valid"},    32'(vga_valid),    32'h0);
        check({tag, " vga_data"},     32'(vga_data),     32'h0);
        check({tag, " core_gnt"},     32'(core_gnt),     32'h0);
        check({tag, " core_rvalid"},  32'(core_rvalid),  32'h0);
        check({tag, " core_rdata"},   32'(core_rdata),   32'h0);
        check({tag, " mem_addr"},     32'(mem_addr),     32'h0);
        check({tag, " mem_wdata"},    32'(mem_wdata),    32'h0);
        check({tag, " mem_we"},       32'(mem_we),       32'h0);
        check({tag, " mem_re"},       32'(mem_re),       32'h0);
        check({tag, " wbuf_level"},   32'(wbuf_level),   32'h0);
        check({tag, " core_starved"}, 32'(core_starved), 32'h0);
    endtask

    typedef struct packed {
        logic        vga_req;
        logic [15:0] vga_addr;
        logic        core_req;
        logic        core_we;
        logic [15:0] core_addr;
        logic [7:0]  core_wdata;
        logic        gnt;
        logic        mem_we;
        logic        mem_re;
        logic [15:0] mem_addr;
        logic [7:0]  mem_wdata;
        logic [2:0]  level;
        logic        vga_valid;
        logic [7:0]  vga_data;
        logic        core_rvalid;
        logic [7:0]  core_rdata;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    // Safety net: the run is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] wq [$];
        logic [23:0] got;
        string       nm;

        // ---------------- vector table ----------------
        for (int s = 0; s < NV; s++) vecs[s] = '0;
        // VGA stream: addr 0..9 in steps 0..9.
        for (int s = 0; s <= 9; s++) begin
            vecs[s].vga_req  = 1'b1;
            vecs[s].vga_addr = 16'(s);
        end
        for (int s = 1; s <= 10; s++) begin
            vecs[s].mem_re   = 1'b1;
            vecs[s].mem_addr = 16'(s - 1);
        end
        for (int s = 3; s <= 12; s++) begin
            vecs[s].vga_valid = 1'b1;
            vecs[s].vga_data  = 8'(8'h40 + s - 3);
        end
        // Posted writes 0x0100..0x0103 <- 0xA0..0xA3 in steps 13..16.
        for (int s = 13; s <= 16; s++) begin
            vecs[s].core_req   = 1'b1;
            vecs[s].core_we    = 1'b1;
            vecs[s].core_addr  = 16'(16'h0100 + s - 13);
            vecs[s].core_wdata = 8'(8'hA0 + s - 13);
            vecs[s].gnt        = 1'b1;
        end
        for (int s = 14; s <= 17; s++) vecs[s].level = 3'd1;
        for (int s = 15; s <= 18; s++) begin
            vecs[s].mem_we    = 1'b1;
            vecs[s].mem_addr  = 16'(16'h0100 + s - 15);
            vecs[s].mem_wdata = 8'(8'hA0 + s - 15);
        end
        // Read-after-write: 0x0200 <- 0x5A, then read 0x0200.
        vecs[19].core_req = 1'b1; vecs[19].core_we = 1'b1;
        vecs[19].core_addr = 16'h0200; vecs[19].core_wdata = 8'h5A; vecs[19].gnt = 1'b1;
        vecs[20].core_req = 1'b1; vecs[20].core_addr = 16'h0200; vecs[20].level = 3'd1;
        vecs[21].core_req = 1'b1; vecs[21].core_addr = 16'h0200; vecs[21].gnt = 1'b1;
        vecs[21].mem_we = 1'b1; vecs[21].mem_addr = 16'h0200; vecs[21].mem_wdata = 8'h5A;
        vecs[22].mem_re = 1'b1; vecs[22].mem_addr = 16'h0200;
        vecs[24].core_rvalid = 1'b1; vecs[24].core_rdata = 8'h5A;

        // ---------------- reset ----------------
        reset = 1'b1; vga_req = 1'b0; vga_addr = '0; core_req = 1'b0;
        core_we = 1'b0; core_addr = '0; core_wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset = 1'b0;

        // ---------------- table run ----------------
        for (int s = 0; s < NV; s++) begin
            cyc(vecs[s].vga_req, vecs[s].vga_addr, vecs[s].core_req,
                vecs[s].core_we, vecs[s].core_addr, vecs[s].core_wdata);
            nm = $sformatf("vec%0d", s);
            check({nm, " core_gnt"},     32'(core_gnt),     32'(vecs[s].gnt));
            check({nm, " mem_we"},       32'(mem_we),       32'(vecs[s].mem_we));
            check({nm, " mem_re"},       32'(mem_re),       32'(vecs[s].mem_re));
            check({nm, " wbuf_level"},   32'(wbuf_level),   32'(vecs[s].level));
            check({nm, " vga_valid"},    32'(vga_valid),    32'(vecs[s].vga_valid));
            check({nm, " core_rvalid"},  32'(core_rvalid),  32'(vecs[s].core_rvalid));
            check({nm, " core_starved"}, 32'(core_starved), 32'h0);
            if (vecs[s].mem_we || vecs[s].mem_re)
                check({nm, " mem_addr"}, 32'(mem_addr), 32'(vecs[s].mem_addr));
            if (vecs[s].mem_we)
                check({nm, " mem_wdata"}, 32'(mem_wdata), 32'(vecs[s].mem_wdata));
            if (vecs[s].vga_valid)
                check({nm, " vga_data"}, 32'(vga_data), 32'(vecs[s].vga_data));
            if (vecs[s].core_rvalid)
                check({nm, " core_rdata"}, 32'(core_rdata), 32'(vecs[s].core_rdata));
        end

        // ---------------- full FIFO under VGA pressure ----------------
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 16'(16'h0010 + i), 1'b1, 1'b1, 16'(16'h0300 + i), 8'(8'hB0 + i));
            check($sformatf("full%0d core_gnt", i), 32'(core_gnt), 32'h1);
            check($sformatf("full%0d wbuf_level", i), 32'(wbuf_level), 32'(i));
        end
        for (int i = 4; i < 6; i++) begin
            cyc(1'b1, 16'(16'h0010 + i), 1'b1, 1'b1, 16'h0304, 8'hB4);
            check($sformatf("full%0d core_gnt refused", i), 32'(core_gnt), 32'h0);
            check($sformatf("full%0d wbuf_level", i), 32'(wbuf_level), 32'h4);
        end
        // VGA drops: the head pops now, but a full buffer still refuses the push.
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 16'h0304, 8'hB4);
        check("full6 no pass-through", 32'(core_gnt), 32'h0);
        check("full6 wbuf_level", 32'(wbuf_level), 32'h4);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 16'h0304, 8'hB4);
        check("full7 core_gnt", 32'(core_gnt), 32'h1);
        check("full7 wbuf_level", 32'(wbuf_level), 32'h3);
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
        for (int i = 0; i < 8; i++) begin
            idle();
            if (mem_we) wq.push_back({mem_addr, mem_wdata});
        end
        check("drain count", 32'(wq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            got = (i < wq.size()) ? wq[i] : 24'hFFFFFF;
            check($sformatf("drain order %0d", i), 32'(got), 32'({16'(16'h0300 + i), 8'(8'hB0 + i)}));
        end
        check("drain wbuf_level", 32'(wbuf_level), 32'h0);

        // ---------------- starvation ----------------
        cyc(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0400, 8'hC0);
        check("starve push core_gnt", 32'(core_gnt), 32'h1);
        // The write is buffered from step 1; after 64 VGA-owned cycles
        // (steps 1..64) the flag is visible at step 65 and saturates until
        // VGA drops after step 69, the write issues at step 70.
        for (int i = 1; i <= 71; i++) begin
            cyc(i <= 69, 16'(16'h0020 + i), 1'b0, 1'b0, 16'h0, 8'h0);
            check($sformatf("starve%0d core_starved", i), 32'(core_starved),
                  32'(i >= 65 && i <= 70));
            check($sformatf("starve%0d mem_we", i), 32'(mem_we), 32'(i == 71));
            if (i == 71) begin
                check("starve write addr", 32'(mem_addr), 32'h0400);
                check("starve write data", 32'(mem_wdata), 32'hC0);
            end
        end
        repeat (4) idle();

        // ---------------- reset during a core read ----------------
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 8'h0);
        check("rst read core_gnt", 32'(core_gnt), 32'h1);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 16'h0500, 8'hEE);
        reset = 1'b1;
        #1;
        check("rst core_gnt held low", 32'(core_gnt), 32'h0);
        idle();
        reset = 1'b0;
        check_all_zero("post-reset");
        for (int i = 0; i < 5; i++) begin
            idle();
            check($sformatf("post-reset%0d core_rvalid", i), 32'(core_rvalid), 32'h0);
            check($sformatf("post-reset%0d mem_re", i), 32'(mem_re), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
